// File: rtl/stream_sum_n.sv
//==============================================================================
// Module      : stream_sum_n
// Description : Drains a counted number of stream elements and returns their
//               N-bit wrapping sum on a ready/valid result port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module stream_sum_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] sIn,
    input  logic         sIn_valid,
    output logic         sIn_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out0
);

    localparam logic [N-1:0] C_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] C_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_acc;
    logic [N-1:0] w_acc_nxt;
    logic [N-1:0] r_remaining;
    logic [N-1:0] w_remaining_nxt;
    logic [N-1:0] r_out0;
    logic [N-1:0] w_out0_nxt;
    logic [N-1:0] w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= C_ZERO;
            r_remaining <= C_ZERO;
            r_out0      <= C_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_remaining <= w_remaining_nxt;
            r_out0      <= w_out0_nxt;
        end
    end

    // Carry out of the top bit is intentionally dropped: the sum wraps mod 2^N.
    assign w_sum = r_acc + sIn;

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_remaining_nxt = r_remaining;
        w_out0_nxt      = r_out0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_remaining_nxt = in0;
                    w_acc_nxt       = C_ZERO;
                    if (in0 == C_ZERO) begin
                        w_out0_nxt  = C_ZERO;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (sIn_valid) begin
                    w_acc_nxt       = w_sum;
                    w_remaining_nxt = r_remaining - C_ONE;
                    if (r_remaining == C_ONE) begin
                        w_out0_nxt  = w_sum;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake readies are pure state decodes, so no input reaches them combinationally.
    assign in_ready  = (r_state == IDLE);
    assign sIn_ready = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign out0      = r_out0;

endmodule

`default_nettype wire

// File: tb/tb_stream_sum_n.sv
//==============================================================================
// Module      : tb_stream_sum_n
// Description : Scoreboard bench for stream_sum_n with directed transactions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stream_sum_n;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in0;
    logic [7:0] sIn;
    logic       sIn_valid;
    logic       sIn_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] elems[$];

    stream_sum_n #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .sIn       (sIn),
        .sIn_valid (sIn_valid),
        .sIn_ready (sIn_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(out0), 32'hFFFF_FFFF);
                end else begin
                    chk("out0", 32'(out0), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Waits at negedges (bounded) until in_ready, then issues a start beat.
    task automatic start_beat(input logic [7:0] cnt);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("start_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in0      = cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Feeds elements[] (optionally with a bubble every other cycle); returns cycles used.
    task automatic feed(input int cnt, input bit bubbles, output int cyc);
        int  idx;
        bit  gap;
        bit  rdy;
        idx = 0;
        gap = 1'b0;
        cyc = 0;
        while (idx < cnt && cyc < 4 * cnt + 20) begin
            if (bubbles && gap) begin
                sIn_valid = 1'b0;
                sIn       = 8'hEE;
            end else begin
                sIn_valid = 1'b1;
                sIn       = elems[idx];
            end
            @(negedge clk);
            rdy = sIn_ready;
            chk("sIn_ready_run", 32'(rdy), 32'd1);
            @(posedge clk);
            if (sIn_valid && rdy) idx++;
            #1;
            gap = !gap;
            cyc++;
        end
        if (idx < cnt) chk("feed_timeout", 32'(idx), 32'(cnt));
        // Keep a valid element on offer to prove nothing extra is consumed.
        sIn_valid = 1'b1;
        sIn       = 8'hFF;
    endtask

    task automatic txn(input logic [7:0] cnt, input logic [7:0] exp_sum,
                       input bit bubbles, input int stall);
        int cyc;
        exp_q.push_back(exp_sum);
        out_ready = (stall == 0);
        sIn_valid = 1'b1;
        sIn       = (cnt != 0) ? elems[0] : 8'hAA;
        start_beat(cnt);
        feed(int'(cnt), bubbles, cyc);
        if (!bubbles) chk("beat_cycles", 32'(cyc), 32'(cnt));
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_sIn_ready", 32'(sIn_ready), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < stall; k++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out0", 32'(out0), 32'(exp_sum));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_sIn_ready", 32'(sIn_ready), 32'd0);
            @(posedge clk);
            #1;
            if (k == stall - 1) out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        sIn_valid = 1'b0;
        @(negedge clk);
        chk("after_in_ready", 32'(in_ready), 32'd1);
        chk("after_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in0       = 8'd0;
        sIn       = 8'd0;
        sIn_valid = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sIn_ready", 32'(sIn_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out0", 32'(out0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        elems = {8'd1, 8'd2, 8'd3};
        txn(8'd3, 8'd6, 1'b0, 0);

        elems = {};
        txn(8'd0, 8'd0, 1'b0, 0);

        elems = {8'd5, 8'd6, 8'd7, 8'd8};
        txn(8'd4, 8'd26, 1'b1, 0);

        elems = {8'd200, 8'd100};
        txn(8'd2, 8'd44, 1'b0, 0);

        elems = {8'd42};
        txn(8'd1, 8'd42, 1'b0, 3);

        // Abandon a transaction after two element beats.
        elems = {8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        out_ready = 1'b1;
        sIn_valid = 1'b1;
        sIn       = elems[0];
        start_beat(8'd5);
        feed(2, 1'b0, cyc);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sIn_ready", 32'(sIn_ready), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sIn_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        elems = {8'd9, 8'd1};
        txn(8'd2, 8'd10, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/stream_sum_n.md
# stream_sum_n

Downstream consumer for stream-producing primitives such as the push-right stage. It accepts a start request carrying an unsigned element count, drains exactly that many elements from an input stream, and returns their wrapping sum as an int on a ready/valid output. It reduces a stream back to a scalar so stream-producing stages can be exercised and composed end to end.

## Interface

- Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- N, default 8 (matches `intN`), width of count, stream data and sum.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, start request valid.
- in_ready, out, 1, start request accepted when high.
- in0, in, N, element count; unsigned; sampled on the start beat.
- sIn, in, N, stream element data.
- sIn_valid, in, 1, stream element valid.
- sIn_ready, out, 1, block consumes the element this cycle when high.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out0, out, N, sum of consumed elements, modulo 2^N.

## Operation

- Handshakes:
  - Start beat: in_valid && in_ready.
  - Element beat: sIn_valid && sIn_ready.
  - Result beat: out_valid && out_ready.
- FSM states: IDLE, RUN, DONE. Outputs are decoded from state:
  - in_ready = (state == IDLE).
  - sIn_ready = (state == RUN).
  - out_valid = (state == DONE).
- IDLE:
  - On a start beat: latch remaining <= in0 and clear acc <= 0.
  - If in0 == 0: go to DONE with out0 <= 0. Otherwise go to RUN.
- RUN:
  - On each element beat: acc <= acc + sIn (N-bit wrap, carry discarded) and remaining <= remaining - 1.
  - On the beat where remaining == 1: out0 <= acc + sIn and go to DONE.
  - Cycles with sIn_valid low change nothing.
- DONE:
  - out0 holds its value.
  - On a result beat, go to IDLE.
  - No new start is accepted in DONE; in_ready stays low.
- Never consume more than count elements. sIn_ready is low in every cycle outside RUN, including the cycle after the last beat.
- All arithmetic is unsigned, N bits. The maximum count is 2^N - 1.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - acc, remaining and out0 go to 0.
  - out_valid = 0, sIn_ready = 0, in_ready = 1 while reset is asserted and after it is released.
  - A transaction in progress is abandoned. Elements already consumed are lost. No partial result is emitted.

## Timing

- Start beat at cycle t with count C > 0 and sIn valid every cycle: element beats at t+1 … t+C, out_valid first high at t+C+1.
- Count 0: out_valid high at t+1 and no element is consumed.
- Each sIn_valid gap cycle adds one cycle of latency.
- out0 is registered. It is stable and valid for every cycle out_valid is high, and it stays stable under backpressure (out_ready low).
- Result beat at cycle r: IDLE at r+1, so in_ready is high at r+1. The minimum start-to-start period is C+2 cycles.
- No combinational path from out_ready or sIn_valid to in_ready or sIn_ready. Ready signals depend only on state.

## Test plan

- Basic sum: reset, then start with in0=3 while sIn presents 1, 2, 3 with sIn_valid held high; out_ready=1 -> exactly 3 element beats, then out_valid=1 with out0=6 at cycle t+4, then in_ready=1 at t+5.
- Zero count: start with in0=0 while sIn_valid=1 -> sIn_ready never asserts, out0=0 and out_valid=1 at t+1.
- Bubbles: in0=4 with elements 5, 6, 7, 8 and sIn_valid low on alternate cycles -> out0=26 after the 4th valid beat, and gap cycles do not change acc.
- Wrap-around: N=8, in0=2 with elements 200 and 100 -> out0=44.
- Backpressure: in0=1 with element 42 and out_ready low for 3 cycles -> out_valid and out0=42 are held for all 3 cycles, in_ready and sIn_ready stay low, and the accept on the 4th cycle returns the block to IDLE.
- Reset mid-RUN: in0=5, assert rst after 2 beats -> immediately out_valid=0, sIn_ready=0, in_ready=1; a following start with in0=2 and elements 9, 1 -> out0=10, with no contribution from the pre-reset elements.
